joy_lastdir_filter: RTL and testbench

//  Multi-player digital-joystick conditioner between raw direction sources (keyboard regs | joystick bits)
//  and game input ports. Per player: sync, debounce, last-pressed-wins 4-way filter, held-direction fallback.

---
 rtl/joy_pkg.sv | 34 +++
 rtl/joy_debounce.sv | 48 ++++
 rtl/joy_lastdir_filter.sv | 88 ++++++++
 tb/tb_joy_lastdir_filter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared direction type, bit positions and helpers for the joystick conditioner.
// Bit order of a dir_t: {up, down, left, right}.
package joy_pkg;

  typedef logic [3:0] dir_t;

  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  // Keep only the highest-priority set bit (up > down > left > right).
  function automatic dir_t dir_onehot_hi(input dir_t d);
    dir_t r;
    r = '0;
    if (d[DIR_UP])         r[DIR_UP]    = 1'b1;
    else if (d[DIR_DOWN])  r[DIR_DOWN]  = 1'b1;
    else if (d[DIR_LEFT])  r[DIR_LEFT]  = 1'b1;
    else if (d[DIR_RIGHT]) r[DIR_RIGHT] = 1'b1;
    return r;
  endfunction

  // Rotate clockwise by rot quarter turns: up->right->down->left->up.
  function automatic dir_t dir_rotate(input dir_t d, input logic [1:0] rot);
    dir_t r;
    r = d;
    for (int unsigned i = 0; i < 3; i++) begin
      if (i < {30'd0, rot})
        r = {r[DIR_LEFT], r[DIR_RIGHT], r[DIR_DOWN], r[DIR_UP]};
    end
    return r;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Two-flop synchronizer plus per-bit debounce for one player's four direction lines.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int DEB_W   = 4,
  parameter int DEB_CNT = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic ce,
  input  dir_t din,
  output dir_t stable
);

  dir_t             sync1;
  dir_t             sync2;
  dir_t             stable_q;
  logic [DEB_W-1:0] cnt [4];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == stable_q[i]) begin
          cnt[i] <= '0;
        end else if (DEB_CNT == 0) begin
          stable_q[i] <= sync2[i];
        end else if (ce) begin
          if (cnt[i] == DEB_W'(DEB_CNT - 1)) begin
            stable_q[i] <= sync2[i];
            cnt[i]      <= '0;
          end else if (cnt[i] != '1) begin
            cnt[i] <= cnt[i] + DEB_W'(1);
          end
        end
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/joy_lastdir_filter.sv
// Multi-player last-pressed-wins 4-way joystick filter with held-direction fallback.
// Optional orientation rotation is built only when JOYDIR_ROTATE_EN is defined.
module joy_lastdir_filter
  import joy_pkg::*;
#(
  parameter int PLAYERS = 2,
  parameter int DEB_W   = 4,
  parameter int DEB_CNT = 8
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [PLAYERS*4-1:0] dir_in,
  input  logic [1:0]           rot,
  output logic [PLAYERS*4-1:0] dir_out,
  output logic [PLAYERS-1:0]   dir_chg,
  output logic                 any_active
);

  logic [PLAYERS*4-1:0] out_next;

`ifndef JOYDIR_ROTATE_EN
  logic unused_rot;
  assign unused_rot = ^rot;
`endif

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    dir_t stable, rvec, stable_d, fresh;
    dir_t mask, mask_next, out_q, out_n;
    logic chg_q;

    joy_debounce #(
      .DEB_W   (DEB_W),
      .DEB_CNT (DEB_CNT)
    ) u_deb (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .ce      (ce),
      .din     (dir_in[4*p +: 4]),
      .stable  (stable)
    );

`ifdef JOYDIR_ROTATE_EN
    assign rvec = dir_rotate(stable, rot);
`else
    assign rvec = stable;
`endif

    assign fresh = rvec & ~stable_d;

    // New press wins; otherwise fall back to the highest still-held direction.
    always_comb begin
      mask_next = mask;
      if (fresh != '0)
        mask_next = dir_onehot_hi(fresh);
      else if (rvec == '0)
        mask_next = '0;
      else if ((mask & rvec) == '0)
        mask_next = dir_onehot_hi(rvec);
    end

    assign out_n = rvec & mask_next;

    always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
        stable_d <= '0;
        mask     <= '0;
        out_q    <= '0;
        chg_q    <= 1'b0;
      end else begin
        stable_d <= rvec;
        mask     <= mask_next;
        out_q    <= out_n;
        chg_q    <= (out_n != out_q);
      end
    end

    assign out_next[4*p +: 4] = out_n;
    assign dir_out[4*p +: 4]  = out_q;
    assign dir_chg[p]         = chg_q;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) any_active <= 1'b0;
    else          any_active <= |out_next;
  end

endmodule

// File: tb/tb_joy_lastdir_filter.sv
// Scoreboard bench: two instances (DEB_CNT=0 and DEB_CNT=8) share stimulus; a reference
// model tracks "current direction" per player and queues the expected outputs per cycle.
module tb_joy_lastdir_filter;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [7:0] dir_in;
  logic [1:0] rot;

  logic [7:0] out0, out8;
  logic [1:0] chg0, chg8;
  logic       any0, any8;

  always #5 clk_sys = ~clk_sys;

  joy_lastdir_filter #(.PLAYERS(2), .DEB_W(4), .DEB_CNT(0)) dut0 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .dir_in(dir_in), .rot(rot),
    .dir_out(out0), .dir_chg(chg0), .any_active(any0)
  );

  joy_lastdir_filter #(.PLAYERS(2), .DEB_W(4), .DEB_CNT(8)) dut8 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .dir_in(dir_in), .rot(rot),
    .dir_out(out8), .dir_chg(chg8), .any_active(any8)
  );

  typedef logic [10:0] resp_t;   // {dir_out[7:0], dir_chg[1:0], any_active}
  resp_t q0[$];
  resp_t q8[$];
  int    tests = 0;
  int    fails = 0;

  // Model state indexed [instance][player]
  logic [3:0] m_h1  [2][2];   // input seen one edge ago
  logic [3:0] m_h2  [2][2];   // input seen two edges ago
  logic [3:0] m_st  [2][2];   // accepted (debounced) directions
  logic [3:0] m_prev[2][2];   // previous rotated vector
  logic [3:0] m_out [2][2];
  int         m_cur [2][2];   // index of current direction, -1 = none
  int         m_cnt [2][2][4];

  int ce_mode = 0;
  int ce_phase = 0;

  function automatic int hi_idx(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  // Clockwise quarter turn on a direction index: up->right->down->left->up.
  function automatic int turn_idx(input int i, input int n);
    int k;
    k = i;
    for (int j = 0; j < n; j++) begin
      case (k)
        3:       k = 0;
        0:       k = 2;
        2:       k = 1;
        default: k = 3;
      endcase
    end
    return k;
  endfunction

  function automatic logic [3:0] view(input logic [3:0] v, input logic [1:0] r);
    logic [3:0] o;
    int n;
`ifdef JOYDIR_ROTATE_EN
    n = int'(r);
`else
    n = 0 * int'(r);
`endif
    o = '0;
    for (int i = 0; i < 4; i++) if (v[i]) o[turn_idx(i, n)] = 1'b1;
    return o;
  endfunction

  task automatic model_step(input int d, input int deb);
    resp_t      r;
    logic [7:0] outs;
    logic [1:0] chgs;
    logic [3:0] rv, nw, o;
    outs = '0;
    chgs = '0;
    for (int p = 0; p < 2; p++) begin
      if (!reset_n) begin
        m_h1[d][p] = '0; m_h2[d][p] = '0; m_st[d][p] = '0; m_prev[d][p] = '0;
        m_out[d][p] = '0; m_cur[d][p] = -1;
        for (int b = 0; b < 4; b++) m_cnt[d][p][b] = 0;
      end else begin
        rv = view(m_st[d][p], rot);
        nw = rv & ~m_prev[d][p];
        if (nw != 0)
          m_cur[d][p] = hi_idx(nw);
        else if (rv == 0)
          m_cur[d][p] = -1;
        else if (m_cur[d][p] < 0 || !rv[m_cur[d][p]])
          m_cur[d][p] = hi_idx(rv);
        o = (m_cur[d][p] < 0) ? 4'b0000 : (4'b0001 << m_cur[d][p]);
        chgs[p] = (o != m_out[d][p]);
        m_out[d][p] = o;
        outs[4*p +: 4] = o;
        for (int b = 0; b < 4; b++) begin
          if (m_h2[d][p][b] == m_st[d][p][b]) m_cnt[d][p][b] = 0;
          else if (deb == 0) m_st[d][p][b] = m_h2[d][p][b];
          else if (ce) begin
            m_cnt[d][p][b]++;
            if (m_cnt[d][p][b] == deb) begin
              m_st[d][p][b] = m_h2[d][p][b];
              m_cnt[d][p][b] = 0;
            end
          end
        end
        m_prev[d][p] = rv;
        m_h2[d][p]   = m_h1[d][p];
        m_h1[d][p]   = dir_in[4*p +: 4];
      end
    end
    r = reset_n ? {outs, chgs, |outs} : '0;
    if (d == 0) q0.push_back(r);
    else        q8.push_back(r);
  endtask

  task automatic tick(input logic [7:0] din, input logic rn);
    @(negedge clk_sys);
    dir_in  = din;
    reset_n = rn;
    if (ce_mode == 0) ce = (ce_phase % 4 == 0);
    else              ce = ($urandom_range(0, 2) == 0);
    ce_phase++;
    model_step(0, 0);
    model_step(1, 8);
  endtask

  task automatic hold(input logic [7:0] din, input int n);
    for (int i = 0; i < n; i++) tick(din, 1'b1);
  endtask

  always @(posedge clk_sys) begin
    resp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      tests++;
      if ({out0, chg0, any0} !== e) begin
        fails++;
        $display("FAIL deb0 t=%0t got out=%b chg=%b any=%b want out=%b chg=%b any=%b",
                 $time, out0, chg0, any0, e[10:3], e[2:1], e[0]);
      end
    end
    if (q8.size() > 0) begin
      e = q8.pop_front();
      tests++;
      if ({out8, chg8, any8} !== e) begin
        fails++;
        $display("FAIL deb8 t=%0t got out=%b chg=%b any=%b want out=%b chg=%b any=%b",
                 $time, out8, chg8, any8, e[10:3], e[2:1], e[0]);
      end
    end
  end

  initial begin
    logic [7:0] rnd_in;
    reset_n = 1'b0;
    ce      = 1'b0;
    dir_in  = '0;
    rot     = 2'd0;
    for (int i = 0; i < 3; i++) tick(8'h00, 1'b0);

    // Fast instance: press, add, release-fallback, combined press, release
    hold(8'h08, 10);
    hold(8'h0A, 10);
    hold(8'h08, 10);
    hold(8'h00, 10);
    hold(8'h05, 10);
    hold(8'h00, 10);

    // Debounce: short glitch on right, then a long hold
    hold(8'h01, 20);
    hold(8'h00, 40);
    hold(8'h01, 45);
    hold(8'h00, 45);

    // Both players, reset pulse mid-hold
    hold(8'h28, 50);
    tick(8'h28, 1'b0);
    hold(8'h28, 50);
    hold(8'h00, 45);

    // Orientation
    rot = 2'd1;
    hold(8'h08, 50);
    rot = 2'd2;
    hold(8'h08, 50);
    hold(8'h00, 45);
    rot = 2'd0;

    // Randomized traffic
    ce_mode = 1;
    rnd_in  = '0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 7) == 0) rnd_in[$urandom_range(0, 7)] = ~rnd_in[$urandom_range(0, 7)];
      if ($urandom_range(0, 199) == 0) rot = 2'($urandom_range(0, 3));
      tick(rnd_in, ($urandom_range(0, 599) != 0));
    end

    repeat (3) @(posedge clk_sys);
    #2;
    tests++;
    if (q0.size() != 0 || q8.size() != 0) begin
      fails++;
      $display("FAIL drain got pending=%0d/%0d want 0/0", q0.size(), q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
